// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display, draw, clear and SRAM signals of the VRAM arbiter
interface vram_arbiter_if #(
   parameter int ADDR_WIDTH = 19,
   parameter int DATA_WIDTH = 4
);
   logic                  i_disp_req;
   logic [ADDR_WIDTH-1:0] i_disp_addr;
   logic [DATA_WIDTH-1:0] o_disp_data;
   logic                  o_disp_valid;
   logic                  i_wr_valid;
   logic [ADDR_WIDTH-1:0] i_wr_addr;
   logic [DATA_WIDTH-1:0] i_wr_data;
   logic                  o_wr_ready;
   logic                  i_clear_start;
   logic                  o_clear_busy;
   logic                  o_clear_done;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic                  o_mem_write;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic [DATA_WIDTH-1:0] i_mem_rdata;
   modport slave (
      input  i_disp_req, i_disp_addr, i_wr_valid, i_wr_addr, i_wr_data, i_clear_start, i_mem_rdata,
      output o_disp_data, o_disp_valid, o_wr_ready, o_clear_busy, o_clear_done,
             o_mem_addr, o_mem_write, o_mem_wdata
   );
   modport master (
      output i_disp_req, i_disp_addr, i_wr_valid, i_wr_addr, i_wr_data, i_clear_start, i_mem_rdata,
      input  o_disp_data, o_disp_valid, o_wr_ready, o_clear_busy, o_clear_done,
             o_mem_addr, o_mem_write, o_mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter (display > clear > draw) with full-screen clear sequencer
module vram_arbiter #(
   parameter int ADDR_WIDTH  = 19,
   parameter int DATA_WIDTH  = 4,
   parameter int DEPTH       = 480000,
   parameter int CLEAR_COLOR = 0
) (
   input logic           clk,
   input logic           w_rst,
   vram_arbiter_if.slave bus
);
   typedef enum logic {IDLE, CLEAR} state_t;
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH);
   state_t                state;
   logic [ADDR_WIDTH-1:0] ptr;
   logic                  disp_q;
   assign bus.o_wr_ready  = (state == IDLE) & ~bus.i_disp_req & ~w_rst;
   assign bus.o_disp_data = bus.i_mem_rdata;
   always_ff @(posedge clk) begin
      if (w_rst) begin
         state            <= IDLE;
         ptr              <= '0;
         disp_q           <= 1'b0;
         bus.o_disp_valid <= 1'b0;
         bus.o_mem_addr   <= '0;
         bus.o_mem_write  <= 1'b0;
         bus.o_mem_wdata  <= '0;
         bus.o_clear_busy <= 1'b0;
         bus.o_clear_done <= 1'b0;
      end else begin
         disp_q           <= bus.i_disp_req;
         bus.o_disp_valid <= disp_q;
         bus.o_mem_write  <= 1'b0;
         bus.o_clear_done <= 1'b0;
         if (bus.i_disp_req) begin
            bus.o_mem_addr <= bus.i_disp_addr;
         end else if (state == CLEAR) begin
            bus.o_mem_addr  <= ptr;
            bus.o_mem_write <= 1'b1;
            bus.o_mem_wdata <= DATA_WIDTH'(CLEAR_COLOR);
            ptr             <= (ptr == LAST) ? '0 : ptr + ADDR_WIDTH'(1);
            if (ptr == LAST) begin
               state            <= IDLE;
               bus.o_clear_busy <= 1'b0;
               bus.o_clear_done <= 1'b1;
            end
         end else if (bus.i_wr_valid) begin
            // out-of-range draws are accepted but never reach the SRAM
            bus.o_mem_addr  <= bus.i_wr_addr;
            bus.o_mem_wdata <= bus.i_wr_data;
            bus.o_mem_write <= {1'b0, bus.i_wr_addr} < LIMIT;
         end
         if (state == IDLE && bus.i_clear_start) begin
            state            <= CLEAR;
            ptr              <= '0;
            bus.o_clear_busy <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random checks of two arbiters (full-size and 16-word) against a reference model
module tb_vram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        disp_req, wr_valid, clear_start;
   logic [18:0] disp_addr, wr_addr;
   logic [3:0]  wr_data, rdata_a, rdata_b;
   logic [3:0]  mem [0:15];
   int          total = 0, bad = 0, busy_n, done_n, done_at;
   int          wlog [$];
   typedef struct {bit clr; int ptr; int addr; bit wr; int wdata; bit v1; bit v2; bit busy; bit done;} mdl_t;
   mdl_t ma, mb;
   always #5 clk = ~clk;
   vram_arbiter_if ifa ();
   vram_arbiter_if ifb ();
   vram_arbiter dut_a (.clk(clk), .w_rst(rst), .bus(ifa));
   vram_arbiter #(.DEPTH(16), .CLEAR_COLOR(5)) dut_b (.clk(clk), .w_rst(rst), .bus(ifb));
   assign ifa.i_disp_req    = disp_req;
   assign ifa.i_disp_addr   = disp_addr;
   assign ifa.i_wr_valid    = wr_valid;
   assign ifa.i_wr_addr     = wr_addr;
   assign ifa.i_wr_data     = wr_data;
   assign ifa.i_clear_start = 1'b0;
   assign ifa.i_mem_rdata   = rdata_a;
   assign ifb.i_disp_req    = disp_req;
   assign ifb.i_disp_addr   = disp_addr;
   assign ifb.i_wr_valid    = wr_valid;
   assign ifb.i_wr_addr     = wr_addr;
   assign ifb.i_wr_data     = wr_data;
   assign ifb.i_clear_start = clear_start;
   assign ifb.i_mem_rdata   = rdata_b;
   // behavioural SRAM behind the 16-word arbiter
   always @(posedge clk) begin
      if (ifb.o_mem_write) mem[ifb.o_mem_addr[3:0]] <= ifb.o_mem_wdata;
      rdata_b <= mem[ifb.o_mem_addr[3:0]];
   end
   function automatic mdl_t nxt(mdl_t m, int depth, int cc, bit r, bit dq, int da, bit wv, int wa, int wd, bit cs);
      mdl_t n = m;
      if (r) begin
         n = '{default: 0};
         return n;
      end
      n.v2 = m.v1;
      n.v1 = dq;
      n.wr = 0;
      n.done = 0;
      if (dq) n.addr = da;
      else if (m.clr) begin
         n.addr = m.ptr;
         n.wr = 1;
         n.wdata = cc;
         n.ptr = m.ptr + 1;
         if (m.ptr == depth - 1) begin
            n.clr = 0;
            n.ptr = 0;
            n.done = 1;
         end
      end else if (wv) begin
         n.addr = wa;
         n.wdata = wd;
         n.wr = wa < depth;
      end
      if (!m.clr && cs) begin
         n.clr = 1;
         n.ptr = 0;
      end
      n.busy = n.clr;
      return n;
   endfunction
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic step(bit r, bit dq, int da, bit wv, int wa, int wd, bit cs);
      rst = r;
      disp_req = dq;
      disp_addr = 19'(da);
      wr_valid = wv;
      wr_addr = 19'(wa);
      wr_data = 4'(wd);
      clear_start = cs;
      rdata_a = 4'($urandom_range(15));
      #1;
      chk("ready_a", 32'(ifa.o_wr_ready), 32'(!ma.clr && !dq && !r));
      chk("ready_b", 32'(ifb.o_wr_ready), 32'(!mb.clr && !dq && !r));
      ma = nxt(ma, 480000, 0, r, dq, da, wv, wa, wd, 1'b0);
      mb = nxt(mb, 16, 5, r, dq, da, wv, wa, wd, cs);
      @(posedge clk);
      #1;
      chk("addr_a", 32'(ifa.o_mem_addr), ma.addr);
      chk("write_a", 32'(ifa.o_mem_write), 32'(ma.wr));
      chk("wdata_a", 32'(ifa.o_mem_wdata), ma.wdata);
      chk("valid_a", 32'(ifa.o_disp_valid), 32'(ma.v2));
      chk("busy_a", 32'(ifa.o_clear_busy), 0);
      chk("addr_b", 32'(ifb.o_mem_addr), mb.addr);
      chk("write_b", 32'(ifb.o_mem_write), 32'(mb.wr));
      chk("wdata_b", 32'(ifb.o_mem_wdata), mb.wdata);
      chk("valid_b", 32'(ifb.o_disp_valid), 32'(mb.v2));
      chk("busy_b", 32'(ifb.o_clear_busy), 32'(mb.busy));
      chk("done_b", 32'(ifb.o_clear_done), 32'(mb.done));
      chk("ddata_a", 32'(ifa.o_disp_data), 32'(rdata_a));
      if (ifb.o_mem_write) wlog.push_back(int'(ifb.o_mem_addr));
      if (ifb.o_clear_busy) busy_n++;
      if (ifb.o_clear_done) done_n++;
   endtask
   initial begin
      ma = '{default: 0};
      mb = '{default: 0};
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 1, 5, 1, 5, 3, 1);
      step(0, 0, 0, 1, 'h12C, 'hA, 0);
      step(0, 0, 0, 1, 480000, 'h7, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 'h100 + i, 1, 3, 'hC, 0);
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0);
      // clear started together with an in-range draw, draws refused during the clear
      wlog.delete();
      busy_n = 0;
      done_n = 0;
      step(0, 0, 0, 1, 3, 9, 1);
      chk("sim_draw_addr", wlog.size() > 0 ? wlog.pop_front() : -1, 3);
      for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 20, 1, 0);
      chk("clr1_writes", wlog.size(), 16);
      for (int i = 0; i < 16; i++) chk("clr1_seq", i < wlog.size() ? wlog[i] : -1, i);
      chk("clr1_busy", busy_n, 16);
      chk("clr1_done", done_n, 1);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 1, i, $urandom_range(15), 0);
      // clear stalled by a display request every other cycle
      wlog.delete();
      busy_n = 0;
      done_n = 0;
      done_at = -1;
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         step(0, i < 32 && i % 2 == 0, $urandom_range(15), 0, 0, 0, 0);
         if (ifb.o_clear_done && done_at < 0) done_at = i + 1;
      end
      chk("clr2_cycles", done_at, 32);
      chk("clr2_busy", busy_n, 32);
      chk("clr2_done", done_n, 1);
      chk("clr2_writes", wlog.size(), 16);
      for (int i = 0; i < 16; i++) chk("clr2_seq", i < wlog.size() ? wlog[i] : -1, i);
      for (int i = 0; i < 16; i++) chk("clr2_mem", 32'(mem[i]), 5);
      // reset while the pointer sits at 7
      done_n = 0;
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 2, 2, 0);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
      chk("rst_no_done", done_n, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(524287),
              $urandom_range(1), $urandom_range(1) ? $urandom_range(31) : $urandom_range(524287),
              $urandom_range(15), $urandom_range(39) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 19, VRAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, bits per pixel.
REQ-003 SHALL have parameter DEPTH, default 480000 (800x600), number of valid VRAM words.
REQ-004 SHALL have parameter CLEAR_COLOR, default 0, value written by the clear sequencer.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port w_rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_disp_req  in  1  scan-out read request, highest priority, no ready.
REQ-008 SHALL have port i_disp_addr  in  ADDR_WIDTH  scan-out read address.
REQ-009 SHALL have port o_disp_data  out  DATA_WIDTH  read data, equal to i_mem_rdata.
REQ-010 SHALL have port o_disp_valid  out  1  o_disp_data holds the result of a display read.
REQ-011 SHALL have port i_wr_valid  in  1  draw-engine write request.
REQ-012 SHALL have port i_wr_addr  in  ADDR_WIDTH  draw write address.
REQ-013 SHALL have port i_wr_data  in  DATA_WIDTH  draw write pixel.
REQ-014 SHALL have port o_wr_ready  out  1  draw write accepted this cycle when high with i_wr_valid.
REQ-015 SHALL have port i_clear_start  in  1  one-cycle pulse that starts a full-screen clear.
REQ-016 SHALL have port o_clear_busy  out  1  clear in progress.
REQ-017 SHALL have port o_clear_done  out  1  one-cycle pulse on clear completion.
REQ-018 SHALL have ports o_mem_addr (ADDR_WIDTH), o_mem_write (1) and o_mem_wdata (DATA_WIDTH), all outputs, driving the single-port SRAM.
REQ-019 SHALL have port i_mem_rdata  in  DATA_WIDTH  SRAM read data, one cycle after address.

Function
REQ-020 SHALL implement states IDLE and CLEAR; in IDLE with i_clear_start=1 the next state is CLEAR with the clear pointer at 0.
REQ-021 SHALL ignore i_clear_start while in CLEAR.
REQ-022 SHALL grant per cycle, in this priority order: display (i_disp_req=1), then clear (state CLEAR), then draw (i_wr_valid=1 in IDLE).
REQ-023 SHALL drive o_wr_ready combinationally as (state==IDLE) & ~i_disp_req & ~w_rst.
REQ-024 SHALL register all o_mem_* outputs: a grant at edge N appears on o_mem_* during cycle N+1.
REQ-025 On a display grant, SHALL set o_mem_addr=i_disp_addr and o_mem_write=0; o_mem_wdata holds its previous value.
REQ-026 On a display grant, SHALL pulse o_disp_valid high exactly 2 cycles after the request edge (one cycle address register plus one cycle SRAM latency).
REQ-027 On a clear grant, SHALL set o_mem_addr=pointer, o_mem_write=1, o_mem_wdata=CLEAR_COLOR, and increment the pointer.
REQ-028 SHALL leave the pointer unchanged on cycles where display wins, so the clear stalls without skipping addresses.
REQ-029 On the clear grant of address DEPTH-1, SHALL return to IDLE and assert o_clear_done for the following cycle, with o_clear_busy low in that same cycle.
REQ-030 On a draw handshake, SHALL set o_mem_addr=i_wr_addr and o_mem_wdata=i_wr_data, with o_mem_write=1 only if i_wr_addr<DEPTH.
REQ-031 SHALL consume and silently drop a draw write with i_wr_addr>=DEPTH (o_mem_write=0).
REQ-032 With no grant, SHALL drive o_mem_write=0 and hold o_mem_addr.
REQ-033 SHALL drive o_clear_busy as a registered (state==CLEAR) signal.
REQ-034 When i_clear_start and a draw handshake occur in the same IDLE cycle, SHALL commit the write and begin the clear on the next cycle.
REQ-035 SHALL never assert o_mem_write in a cycle following a display grant.

Reset
REQ-036 On w_rst=1 at an edge, SHALL set state=IDLE, pointer=0, o_mem_addr=0, o_mem_write=0, o_mem_wdata=0, o_disp_valid=0 (including the delay pipeline), o_clear_busy=0 and o_clear_done=0.
REQ-037 A reset during CLEAR SHALL abort the clear with no o_clear_done pulse; memory already written stays written.

Verification
REQ-038 Display priority: i_disp_req=1 and i_wr_valid=1 for 3 cycles -> o_wr_ready=0 throughout, o_mem_write=0, o_disp_valid high on cycles 2-4.
REQ-039 Draw write: idle display, i_wr_valid=1, addr=0x12C, data=0xA -> next cycle o_mem_addr=0x12C, o_mem_write=1, o_mem_wdata=0xA.
REQ-040 Out of range: addr=480000 accepted (ready=1) -> o_mem_write=0 next cycle.
REQ-041 Clear with DEPTH=16 and display idle -> 16 consecutive writes of CLEAR_COLOR to addresses 0..15, o_clear_busy high 16 cycles, single o_clear_done pulse, draw ready low throughout.
REQ-042 Clear with DEPTH=16 and i_disp_req toggling every cycle -> 16 writes with no skipped or repeated address, 32 cycles to o_clear_done.
REQ-043 Reset asserted at pointer 7 mid-clear -> all outputs at reset values next cycle, no o_clear_done, o_wr_ready=1 after reset release.
